// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter slice.
// Holds the arbiter state encoding and the baud divisor calculation.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } uart_arb_state_t;

    function automatic int uart_div(input int bus_clk, input int baud);
        return bus_clk / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running baud clock enable: one-cycle tick every DIV clocks, never paused.
// Tick is registered and fires in the cycle after the counter wraps from DIV-1.
module uart_baud_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one uart_tx among NUM_REQ byte sources; 1-cycle arbitration, one byte per grant.
// Sources hold req_valid until req_ready; UART_TX_ARB_LOCK_EN adds req_lock burst regrant.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int BUS_CLK = 10_000_000,
    parameter int BAUD    = 9600,
    localparam int IDW    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_lock,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   baud_tick,
    output logic                   uart_send,
    output logic [7:0]             uart_dout,
    input  logic                   uart_busy,
    output logic [IDW-1:0]         grant_id,
    output logic                   active
);

    localparam int DIV = uart_div(BUS_CLK, BAUD);

    uart_arb_state_t state;
    logic [7:0]      dat [NUM_REQ];
    logic [IDW-1:0]  nxt_id;
    logic [IDW-1:0]  cand;
    logic            any_vld;

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (baud_tick)
    );

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_dat
        assign dat[i] = req_data[i*8 +: 8];
    end

    // Scan from farthest to nearest so the index closest after grant_id wins.
    always_comb begin
        nxt_id  = grant_id;
        any_vld = 1'b0;
        cand    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDW'((int'(grant_id) + i) % NUM_REQ);
            if (req_valid[cand]) begin
                nxt_id  = cand;
                any_vld = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == LOAD && baud_tick && req_valid[grant_id])
            req_ready[grant_id] = 1'b1;
    end

`ifndef UART_TX_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            uart_send <= 1'b0;
            uart_dout <= '0;
            grant_id  <= IDW'(NUM_REQ - 1);
            active    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_vld) begin
                        grant_id  <= nxt_id;
                        uart_dout <= dat[nxt_id];
                        uart_send <= 1'b1;
                        active    <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    // A withdrawn request abandons the grant before uart_tx can sample send.
                    if (!req_valid[grant_id]) begin
                        uart_send <= 1'b0;
                        active    <= 1'b0;
                        state     <= IDLE;
                    end else if (baud_tick) begin
                        uart_send <= 1'b0;
                        state     <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (uart_busy)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!uart_busy) begin
`ifdef UART_TX_ARB_LOCK_EN
                        if (req_lock[grant_id] && req_valid[grant_id]) begin
                            uart_dout <= dat[grant_id];
                            uart_send <= 1'b1;
                            state     <= LOAD;
                        end else begin
                            active <= 1'b0;
                            state  <= IDLE;
                        end
`else
                        active <= 1'b0;
                        state  <= IDLE;
`endif
                    end
                end
                default: begin
                    uart_send <= 1'b0;
                    active    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx load and a line receiver.
// Build with +define+UART_TX_ARB_LOCK_EN to exercise the burst-lock expectations.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_lock;
    logic [3:0]  req_ready;
    logic        baud_tick;
    logic        uart_send;
    logic [7:0]  uart_dout;
    logic        uart_busy;
    logic [1:0]  grant_id;
    logic        active;

    uart_tx_arbiter #(
        .NUM_REQ (4),
        .BUS_CLK (10_000_000),
        .BAUD    (1_000_000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .baud_tick (baud_tick),
        .uart_send (uart_send),
        .uart_dout (uart_dout),
        .uart_busy (uart_busy),
        .grant_id  (grant_id),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int rdy_offtick = 0;
    int rdy_q[$];
    logic [9:0] rx_q[$];
    int exp_ids[$];
    int exp_bytes[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // uart_tx load: start bit, 8 data bits LSB first, stop bit, busy until the tick after stop.
    logic       tx_line;
    logic       tx_busy;
    logic [8:0] tx_sh;
    logic [3:0] tx_cnt;
    assign uart_busy = tx_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_line <= 1'b1;
            tx_busy <= 1'b0;
            tx_sh   <= '0;
            tx_cnt  <= '0;
        end else if (baud_tick) begin
            if (!tx_busy) begin
                if (uart_send) begin
                    tx_line <= 1'b0;
                    tx_sh   <= {1'b1, uart_dout};
                    tx_cnt  <= 4'd9;
                    tx_busy <= 1'b1;
                end
            end else if (tx_cnt != 4'd0) begin
                tx_line <= tx_sh[0];
                tx_sh   <= {1'b0, tx_sh[8:1]};
                tx_cnt  <= tx_cnt - 4'd1;
            end else begin
                tx_busy <= 1'b0;
            end
        end
    end

    // Line receiver: frame = {stop, data[7:0], start}, sampled mid-bit at 10 clocks/bit.
    logic [9:0] rx_f;
    initial begin
        forever begin
            @(negedge clk);
            if (tx_line === 1'b0) begin
                repeat (5) @(negedge clk);
                rx_f[0] = tx_line;
                for (int b = 1; b < 10; b++) begin
                    repeat (10) @(negedge clk);
                    rx_f[b] = tx_line;
                end
                rx_q.push_back(rx_f);
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i] === 1'b1) begin
                rdy_q.push_back(i);
                if (baud_tick !== 1'b1) rdy_offtick++;
            end
        end
    end

    task automatic wait_rdy(input int n);
        int k = 0;
        while (rdy_q.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("rdy_wait", 32'(rdy_q.size() >= n), 32'd1);
    endtask

    task automatic wait_rx(input int n);
        int k = 0;
        while (rx_q.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("rx_wait", 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic expect_b(input int id, input int b);
        exp_ids.push_back(id);
        exp_bytes.push_back(b);
    endtask

    task automatic chk_run(input string tag);
        chk({tag, "_nrdy"}, rdy_q.size(), exp_ids.size());
        for (int i = 0; i < exp_ids.size(); i++)
            if (i < rdy_q.size()) chk({tag, "_id"}, rdy_q[i], exp_ids[i]);
        chk({tag, "_nrx"}, rx_q.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size(); i++)
            if (i < rx_q.size()) chk({tag, "_frame"}, 32'(rx_q[i]), 32'({1'b1, 8'(exp_bytes[i]), 1'b0}));
        rdy_q.delete();
        rx_q.delete();
        exp_ids.delete();
        exp_bytes.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt, first, last, per, bad, k, n1;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_lock  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_tick",  32'(baud_tick), 32'h0);
        chk("rst_send",  32'(uart_send), 32'h0);
        chk("rst_dout",  32'(uart_dout), 32'h0);
        chk("rst_gid",   32'(grant_id),  32'h3);
        chk("rst_act",   32'(active),    32'h0);
        rst_n = 1'b1;

        // 1: idle baud ticks every 10 clocks, line quiet
        nt = 0; first = 0; last = 0; per = 0; bad = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (baud_tick === 1'b1) begin
                if (nt == 0) first = c;
                else per = c - last;
                last = c;
                nt++;
            end
            if (uart_send !== 1'b0 || active !== 1'b0 || tx_line !== 1'b1) bad++;
        end
        chk("t1_ticks", nt, 10);
        chk("t1_first", first, 10);
        chk("t1_period", per, 10);
        chk("t1_quiet", bad, 0);

        // 2: single byte A5 from requester 0
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        wait_rdy(1);
        req_valid = '0;
        wait_rx(1);
        repeat (20) @(negedge clk);
        expect_b(0, 8'hA5);
        chk_run("t2");

        // 3: all four held, rotation from reset grant_id=3
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_data  = 32'h13121110;
        req_valid = 4'b1111;
        wait_rdy(5);
        req_valid = '0;
        wait_rx(5);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 5; i++) expect_b(i % 4, 8'h10 + (i % 4));
        chk_run("t3");

        // 4: requester 2 withdraws in LOAD before the tick
        k = 0;
        while (baud_tick !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t4_tick_wait", 32'(baud_tick), 32'h1);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("t4_gid", 32'(grant_id), 32'h2);
        chk("t4_act", 32'(active), 32'h1);
        chk("t4_send", 32'(uart_send), 32'h1);
        req_valid = 4'b1001;
        @(negedge clk);
        chk("t4_wd_act", 32'(active), 32'h0);
        chk("t4_wd_gid", 32'(grant_id), 32'h2);
        chk("t4_wd_send", 32'(uart_send), 32'h0);
        wait_rdy(1);
        req_valid = '0;
        wait_rx(1);
        repeat (20) @(negedge clk);
        expect_b(3, 8'h13);
        chk_run("t4");

        // 5: requester 1 requests a locked burst of three
        req_lock  = 4'b0010;
        req_valid = 4'b0011;
        k = 0;
        while (rdy_q.size() < 5 && k < 3000) begin
            @(negedge clk);
            k++;
            n1 = 0;
            foreach (rdy_q[j]) if (rdy_q[j] == 1) n1++;
            if (n1 >= 3) req_lock = '0;
        end
        req_valid = '0;
        req_lock  = '0;
        chk("t5_wait", 32'(rdy_q.size()), 32'd5);
        wait_rx(5);
        repeat (20) @(negedge clk);
`ifdef UART_TX_ARB_LOCK_EN
        expect_b(0, 8'h10); expect_b(1, 8'h11); expect_b(1, 8'h11);
        expect_b(1, 8'h11); expect_b(0, 8'h10);
`else
        expect_b(0, 8'h10); expect_b(1, 8'h11); expect_b(0, 8'h10);
        expect_b(1, 8'h11); expect_b(0, 8'h10);
`endif
        chk_run("t5");

        // 6: asynchronous reset during data bit 4, then a clean byte
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_data[7:0] = 8'h5A;
        req_valid     = 4'b0001;
        wait_rdy(1);
        req_valid = '0;
        repeat (54) @(negedge clk);
        chk("t6_pre_act", 32'(active), 32'h1);
        chk("t6_pre_dout", 32'(uart_dout), 32'h5A);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_ready", 32'(req_ready), 32'h0);
        chk("t6_tick",  32'(baud_tick), 32'h0);
        chk("t6_send",  32'(uart_send), 32'h0);
        chk("t6_dout",  32'(uart_dout), 32'h0);
        chk("t6_gid",   32'(grant_id),  32'h3);
        chk("t6_act",   32'(active),    32'h0);
        chk("t6_tx",    32'(tx_line),   32'h1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        rdy_q.delete();
        rx_q.delete();
        req_data[7:0] = 8'h3C;
        req_valid     = 4'b0001;
        wait_rdy(1);
        req_valid = '0;
        wait_rx(1);
        repeat (20) @(negedge clk);
        expect_b(0, 8'h3C);
        chk_run("t6");

        chk("rdy_on_tick", rdy_offtick, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
